// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time, buffers returned
// instructions in a 2-entry FIFO for decode, and drives the registered next-PC.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic [31:0] iPC,
    input  logic        iHalt,
    output logic [31:0] oNextPC,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemGnt,
    input  logic        iMemRdValid,
    input  logic [31:0] iMemRdData,
    output logic        oInstrValid,
    output logic [31:0] oInstr,
    output logic [31:0] oInstrPC,
    input  logic        iDecodeReady,
    output logic [1:0]  oDbgState
);
    // Handshakes: a memory request transfers on a cycle with oMemReq&iMemGnt and
    // oMemReq/oMemAddr hold until then; exactly one iMemRdValid follows each
    // transfer. An instruction transfers on oInstrValid&iDecodeReady and the
    // head (oInstr/oInstrPC) holds while decode stalls.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} fetchStateT;

    fetchStateT  state;
    logic        discard;
    logic [31:0] inflightPC;
    logic [1:0]  count;
    logic [31:0] fifoInstr [2];
    logic [31:0] fifoPC [2];
    logic        push;
    logic        pop;

    assign push        = (state == WAIT) && iMemRdValid && !discard && !iRedirect;
    assign pop         = oInstrValid && iDecodeReady && !iRedirect;
    assign oInstrValid = (count != 2'd0);
    assign oInstr      = fifoInstr[0];
    assign oInstrPC    = fifoPC[0];
    assign oDbgState   = state;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state      <= IDLE;
            oNextPC    <= RESET_PC;
            oMemReq    <= 1'b0;
            oMemAddr   <= '0;
            inflightPC <= '0;
            discard    <= 1'b0;
        end else begin
            if (iRedirect) begin
                oNextPC <= iRedirectPC;
            end
            case (state)
                IDLE: begin
                    if (!iRedirect && !iHalt && (count < 2'd2)) begin
                        state      <= REQ;
                        oMemReq    <= 1'b1;
                        oMemAddr   <= iPC;
                        inflightPC <= iPC;
                    end
                end
                REQ: begin
                    if (iRedirect) begin
                        discard <= 1'b1;
                    end
                    if (iMemGnt) begin
                        oMemReq <= 1'b0;
                        state   <= WAIT;
                        if (!iRedirect && !discard) begin
                            oNextPC <= oMemAddr + 32'd4;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving with a redirect is the one being
                    // flushed, so the discard flag must not outlive it.
                    if (iMemRdValid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (iRedirect) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift FIFO: entry 0 is always the head presented to decode.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            count        <= 2'd0;
            fifoInstr[0] <= '0;
            fifoInstr[1] <= '0;
            fifoPC[0]    <= '0;
            fifoPC[1]    <= '0;
        end else if (iRedirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    fifoInstr[count[0]] <= iMemRdData;
                    fifoPC[count[0]]    <= inflightPC;
                    count               <= count + 2'd1;
                end
                2'b01: begin
                    fifoInstr[0] <= fifoInstr[1];
                    fifoPC[0]    <= fifoPC[1];
                    count        <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifoInstr[0] <= iMemRdData;
                        fifoPC[0]    <= inflightPC;
                    end else begin
                        fifoInstr[0] <= fifoInstr[1];
                        fifoPC[0]    <= fifoPC[1];
                        fifoInstr[1] <= iMemRdData;
                        fifoPC[1]    <= inflightPC;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: reset/timing table, directed corner
// sequences, and randomized traffic checked against a fetch-stream model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic [31:0] iPC;
    logic        iHalt = 1'b0;
    logic [31:0] oNextPC;
    logic        iRedirect = 1'b0;
    logic [31:0] iRedirectPC = '0;
    logic        oMemReq;
    logic [31:0] oMemAddr;
    logic        iMemGnt = 1'b0;
    logic        iMemRdValid = 1'b0;
    logic [31:0] iMemRdData = '0;
    logic        oInstrValid;
    logic [31:0] oInstr;
    logic [31:0] oInstrPC;
    logic        iDecodeReady = 1'b0;
    logic [1:0]  oDbgState;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .iClk(iClk), .iReset(iReset), .iPC(iPC), .iHalt(iHalt), .oNextPC(oNextPC),
        .iRedirect(iRedirect), .iRedirectPC(iRedirectPC), .oMemReq(oMemReq),
        .oMemAddr(oMemAddr), .iMemGnt(iMemGnt), .iMemRdValid(iMemRdValid),
        .iMemRdData(iMemRdData), .oInstrValid(oInstrValid), .oInstr(oInstr),
        .oInstrPC(oInstrPC), .iDecodeReady(iDecodeReady), .oDbgState(oDbgState)
    );

    // The PC register passes oNextPC straight through.
    assign iPC = oNextPC;

    always #5 iClk = ~iClk;

    int testsRun = 0;
    int testsFailed = 0;

    // stimulus controls
    logic        rdy = 1'b1;
    logic        halt = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redirPC = '0;
    int          gntMode = 1;   // 0 never, 1 always, 2 random
    int          rspMinDelay = 0;
    int          rspMaxDelay = 0;

    // memory model
    logic        rspPending = 1'b0;
    int          rspCount = 0;
    logic [31:0] rspAddr = '0;

    // fetch-stream reference: decode must see consecutive words from the last redirect
    logic [31:0] expPc = RESET_PC;
    logic [31:0] lastPc = '0;
    int          consumed = 0;

    logic        prevReqHeld = 1'b0;
    logic [31:0] prevAddr = '0;
    logic        prevStall = 1'b0;
    logic [31:0] prevInstr = '0;
    logic [31:0] prevInstrPC = '0;

    typedef struct {
        logic        rdy;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expNext;
        logic        expValid;
        logic [31:0] expPc;
    } vecT;
    vecT vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic consume;
        @(negedge iClk);
        if (prevReqHeld) begin
            check("req_held", {31'b0, oMemReq}, 32'd1);
            check("addr_held", oMemAddr, prevAddr);
        end
        if (prevStall) begin
            check("stall_valid", {31'b0, oInstrValid}, 32'd1);
            check("stall_instr", oInstr, prevInstr);
            check("stall_pc", oInstrPC, prevInstrPC);
        end
        iDecodeReady = rdy;
        iHalt        = halt;
        iRedirect    = redir;
        iRedirectPC  = redirPC;
        case (gntMode)
            0:       iMemGnt = 1'b0;
            1:       iMemGnt = oMemReq;
            default: iMemGnt = oMemReq && ($urandom_range(99) < 60);
        endcase
        iMemRdValid = rspPending && (rspCount == 0);
        iMemRdData  = rspAddr ^ KEY;
        if (rspPending) begin
            if (rspCount == 0) rspPending = 1'b0;
            else rspCount--;
        end
        if (oMemReq && iMemGnt) begin
            rspPending = 1'b1;
            rspAddr    = oMemAddr;
            rspCount   = $urandom_range(rspMaxDelay, rspMinDelay);
        end
        consume = oInstrValid && rdy && !redir;
        if (consume) begin
            check("instr_pc", oInstrPC, expPc);
            check("instr_data", oInstr, expPc ^ KEY);
            lastPc = oInstrPC;
            consumed++;
            expPc = expPc + 32'd4;
        end
        if (redir) expPc = redirPC;
        prevReqHeld = oMemReq && !iMemGnt;
        prevAddr    = oMemAddr;
        prevStall   = oInstrValid && !rdy && !redir;
        prevInstr   = oInstr;
        prevInstrPC = oInstrPC;
    endtask

    task automatic doReset();
        iReset = 1'b1;
        halt = 1'b0; redir = 1'b0;
        iHalt = 1'b0; iRedirect = 1'b0; iMemGnt = 1'b0; iMemRdValid = 1'b0;
        iDecodeReady = rdy;
        rspPending = 1'b0; prevReqHeld = 1'b0; prevStall = 1'b0;
        expPc = RESET_PC; consumed = 0;
        @(negedge iClk);
        @(negedge iClk);
        check("rst_nextpc", oNextPC, RESET_PC);
        check("rst_memreq", {31'b0, oMemReq}, 32'd0);
        check("rst_memaddr", oMemAddr, 32'd0);
        check("rst_valid", {31'b0, oInstrValid}, 32'd0);
        check("rst_instr", oInstr, 32'd0);
        check("rst_instrpc", oInstrPC, 32'd0);
        iReset = 1'b0;
    endtask

    task automatic waitReq(input string name, input int bound);
        int n = 0;
        while (!oMemReq && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'b0, oMemReq}, 32'd1);
    endtask

    task automatic waitConsume(input string name, input int bound);
        int c = consumed;
        int n = 0;
        while (consumed == c && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'b0, consumed > c}, 32'd1);
    endtask

    task automatic waitGrantOf(input string name, input logic [31:0] addr, input int bound);
        int n = 0;
        while (!(rspPending && rspAddr == addr) && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'b0, rspPending && rspAddr == addr}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h100, 32'h100, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h104, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h104, 1'b1, 32'h100};
        vecs[3] = '{1'b1, 1'b1, 32'h104, 32'h104, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h108, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h104, 32'h108, 1'b1, 32'h104};
        vecs[6] = '{1'b1, 1'b1, 32'h108, 32'h108, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h108, 32'h10C, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h108, 32'h10C, 1'b1, 32'h108};
        vecs[9] = '{1'b1, 1'b1, 32'h10C, 32'h10C, 1'b0, 32'h0};

        // best-case fetch timing after reset release
        rdy = 1'b1; gntMode = 1; rspMinDelay = 0; rspMaxDelay = 0;
        doReset();
        for (int i = 0; i < 10; i++) begin
            rdy = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_req", i), {31'b0, oMemReq}, {31'b0, vecs[i].expReq});
            check($sformatf("vec%0d_addr", i), oMemAddr, vecs[i].expAddr);
            check($sformatf("vec%0d_next", i), oNextPC, vecs[i].expNext);
            check($sformatf("vec%0d_valid", i), {31'b0, oInstrValid}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid) begin
                check($sformatf("vec%0d_ipc", i), oInstrPC, vecs[i].expPc);
                check($sformatf("vec%0d_instr", i), oInstr, vecs[i].expPc ^ KEY);
            end
        end

        // decode stall fills exactly two entries, then drains in order
        rdy = 1'b0;
        doReset();
        for (int i = 0; i < 10; i++) tick();
        check("stall_full_valid", {31'b0, oInstrValid}, 32'd1);
        check("stall_full_pc", oInstrPC, 32'h100);
        check("stall_full_instr", oInstr, 32'h100 ^ KEY);
        check("stall_nextpc", oNextPC, 32'h108);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_noreq", {31'b0, oMemReq}, 32'd0);
        end
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("drain_count", {31'b0, consumed >= 3}, 32'd1);

        // redirect while the 0x108 response is pending
        rspMinDelay = 3; rspMaxDelay = 3;
        doReset();
        waitGrantOf("wait_grant_108", 32'h108, 60);
        redir = 1'b1; redirPC = 32'h2000;
        tick();
        redir = 1'b0;
        tick();
        check("rw_nextpc", oNextPC, 32'h2000);
        check("rw_flushed", {31'b0, oInstrValid}, 32'd0);
        waitReq("rw_req_timeout", 20);
        check("rw_addr", oMemAddr, 32'h2000);
        rspMinDelay = 0; rspMaxDelay = 0;
        waitConsume("rw_consume_timeout", 30);
        check("rw_first_pc", lastPc, 32'h2000);

        // redirect on the same cycle as the grant for 0x10C
        doReset();
        waitGrantOf("wait_grant_108b", 32'h108, 40);
        gntMode = 0;
        begin
            int n = 0;
            while (!(oMemReq && oMemAddr == 32'h10C) && n < 20) begin
                tick();
                n++;
            end
        end
        check("rg_req_10c", {31'b0, oMemReq && oMemAddr == 32'h10C}, 32'd1);
        gntMode = 1; redir = 1'b1; redirPC = 32'h3000;
        tick();
        redir = 1'b0;
        tick();
        check("rg_nextpc", oNextPC, 32'h3000);
        waitReq("rg_req_timeout", 20);
        check("rg_addr", oMemAddr, 32'h3000);
        waitConsume("rg_consume_timeout", 30);
        check("rg_first_pc", lastPc, 32'h3000);

        // halt while a response is in flight
        rspMinDelay = 3; rspMaxDelay = 3;
        doReset();
        waitGrantOf("wait_grant_100", 32'h100, 10);
        halt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_noreq", {31'b0, oMemReq}, 32'd0);
        end
        check("halt_consumed", consumed, 32'd1);
        check("halt_last_pc", lastPc, 32'h100);
        check("halt_nextpc", oNextPC, 32'h104);
        halt = 1'b0;
        waitReq("halt_req_timeout", 10);
        check("halt_resume_addr", oMemAddr, 32'h104);

        // next-PC wraps past the top of the address space
        rspMinDelay = 0; rspMaxDelay = 0;
        doReset();
        redir = 1'b1; redirPC = 32'hFFFF_FFFC;
        tick();
        redir = 1'b0;
        begin
            int n = 0;
            while (!(oMemReq && oMemAddr == 32'hFFFF_FFFC) && n < 20) begin
                tick();
                n++;
            end
        end
        check("wrap_req", {31'b0, oMemReq && oMemAddr == 32'hFFFF_FFFC}, 32'd1);
        tick();
        check("wrap_nextpc", oNextPC, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        check("wrap_consumed", {31'b0, consumed >= 2}, 32'd1);

        // randomized traffic against the stream model
        gntMode = 2; rspMinDelay = 0; rspMaxDelay = 3;
        doReset();
        for (int i = 0; i < 1500; i++) begin
            rdy     = ($urandom_range(99) < 70);
            halt    = ($urandom_range(99) < 10);
            redir   = ($urandom_range(99) < 4);
            redirPC = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        check("rand_progress", {31'b0, consumed >= 50}, 32'd1);

        // reset in the middle of a transaction takes effect immediately
        rdy = 1'b0; halt = 1'b0; redir = 1'b0; gntMode = 0;
        waitReq("midrst_req_timeout", 20);
        #2 iReset = 1'b1;
        #1;
        check("midrst_memreq", {31'b0, oMemReq}, 32'd0);
        check("midrst_memaddr", oMemAddr, 32'd0);
        check("midrst_valid", {31'b0, oInstrValid}, 32'd0);
        check("midrst_nextpc", oNextPC, RESET_PC);
        gntMode = 1;
        doReset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
